// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package load_store_unit_pkg;

  // Transaction sequencing: accept in IDLE, wait for the bus in ACCESS, release in DONE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  // Access width decoded from funct3[1:0]
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load alignment: shifts the addressed byte/halfword of a bus word down to
// bit 0 and sign- or zero-extends it to a full 32-bit result.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  lsu_size_t   size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Bring the addressed lane to the bottom, then extend from bit 7 or bit 15
  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_B:    result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_H:    result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns a MEM-stage access into a single
// outstanding byte-enabled bus transaction, stalls the pipeline while it is
// in flight, and returns aligned/extended load data to the result mux.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  output logic                  fault,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  lsu_state_t            state;
  lsu_state_t            state_next;

  lsu_size_t             size_req;
  logic                  f3_legal;
  logic                  aligned;
  logic                  access_ok;
  logic                  accept;
  logic [3:0]            be_req;
  logic [DATA_WIDTH-1:0] wdata_req;

  lsu_size_t             size_p1;
  logic                  sign_p1;
  logic [1:0]            offset_p1;
  logic [DATA_WIDTH-1:0] load_value;

  // Decode size, funct3 legality and natural alignment of the incoming request
  always_comb begin
    size_req = SZ_W;
    f3_legal = 1'b0;
    aligned  = 1'b0;
    case (funct3)
      F3_B, F3_BU: size_req = SZ_B;
      F3_H, F3_HU: size_req = SZ_H;
      default:     size_req = SZ_W;
    endcase
    if (mem_write)
      f3_legal = funct3 inside {F3_B, F3_H, F3_W};
    else
      f3_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    case (size_req)
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign access_ok = f3_legal & aligned;
  assign accept    = (state == IDLE) & mem_en & access_ok;

  // Store lane enables and lane-replicated data; loads read the whole word
  always_comb begin
    be_req    = 4'b1111;
    wdata_req = write_data;
    if (mem_write) begin
      case (size_req)
        SZ_B: begin
          be_req    = 4'b0001 << addr[1:0];
          wdata_req = {4{write_data[7:0]}};
        end
        SZ_H: begin
          be_req    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_req = {2{write_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: DONE always returns to IDLE so a held mem_en cannot re-issue
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)  state_next = ACCESS;
      ACCESS:  if (bus_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: request while in ACCESS, stall from acceptance until the ack
  always_comb begin
    bus_req = 1'b0;
    stall   = 1'b0;
    fault   = 1'b0;
    case (state)
      IDLE: begin
        stall = mem_en & access_ok;
        fault = mem_en & ~access_ok;
      end
      ACCESS: begin
        bus_req = 1'b1;
        stall   = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture: bus fields and load shaping info held stable through ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
      size_p1   <= SZ_W;
      sign_p1   <= 1'b0;
      offset_p1 <= 2'b00;
    end else if (accept) begin
      bus_we    <= mem_write;
      bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
      bus_be    <= be_req;
      bus_wdata <= wdata_req;
      size_p1   <= size_req;
      sign_p1   <= ~funct3[2];
      offset_p1 <= addr[1:0];
    end
  end

  load_extend u_load_extend (
    .word      (bus_rdata),
    .offset    (offset_p1),
    .size      (size_p1),
    .is_signed (sign_p1),
    .result    (load_value)
  );

  // Load result register: updated only by a completed load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      read_data <= '0;
    else if ((state == ACCESS) && bus_ack && !bus_we)
      read_data <= load_value;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed and random
// accesses and queues the expected bus request, load result and faults; a
// monitor pops and compares them as the DUT presents each event.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        stall;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .write_data(write_data),
    .read_data(read_data), .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    bit        we;
    bit [31:0] a;
    bit [3:0]  be;
    bit [31:0] wd;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  bit [31:0]   rd_q[$];
  int          fault_q[$];
  int          checks = 0;
  int          errors = 0;
  bit [31:0]   model_rd = 32'd0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Reference rules, written from the access definitions
  function automatic bit legal_op(input bit we, input bit [2:0] f3, input bit [31:0] a);
    bit ok;
    int nbytes;
    if (we) ok = f3 inside {3'd0, 3'd1, 3'd2};
    else    ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    nbytes = 1 << f3[1:0];
    return ok && ((int'(a[1:0]) % nbytes) == 0);
  endfunction

  function automatic bit [31:0] load_model(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] w);
    longint v;
    int sh;
    sh = 8 * int'(a[1:0]);
    v = longint'(w >> sh);
    if (f3[1:0] == 2'd0) v = v % 256;
    if (f3[1:0] == 2'd1) v = v % 65536;
    if (!f3[2] && f3[1:0] == 2'd0 && v >= 128)   v = v - 256;
    if (!f3[2] && f3[1:0] == 2'd1 && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  function automatic bit [3:0] store_be(input bit [2:0] f3, input bit [31:0] a);
    int lane;
    lane = int'(a[1:0]);
    if (f3 == 3'd0) return 4'(1 << lane);
    if (f3 == 3'd1) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic bit [31:0] store_wd(input bit [2:0] f3, input bit [31:0] w);
    if (f3 == 3'd0) return (w & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  // Monitor: compares bus requests, load completions and faults as they appear
  bit          in_access = 1'b0;
  bit          done_pending = 1'b0;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  initial begin
    bus_exp_t  e;
    bit [31:0] exp_rd;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_access    = 1'b0;
        done_pending = 1'b0;
      end else begin
        if (done_pending) begin
          done_pending = 1'b0;
          chk("done_stall", 32'(stall), 32'd0);
          chk("done_no_req", 32'(bus_req), 32'd0);
          if (rd_q.size() == 0) fail_now("unexpected_completion");
          else begin
            exp_rd = rd_q.pop_front();
            chk("read_data", read_data, exp_rd);
          end
        end
        if (bus_req) begin
          if (!in_access) begin
            in_access = 1'b1;
            cap_we    = bus_we;
            cap_addr  = bus_addr;
            cap_be    = bus_be;
            cap_wdata = bus_wdata;
            if (bus_q.size() == 0) fail_now("unexpected_request");
            else begin
              e = bus_q.pop_front();
              chk("bus_we", 32'(bus_we), 32'(e.we));
              chk("bus_addr", bus_addr, e.a);
              chk("bus_be", 32'(bus_be), 32'(e.be));
              if (e.we) chk("bus_wdata", bus_wdata, e.wd);
            end
          end else begin
            chk("hold_we", 32'(bus_we), 32'(cap_we));
            chk("hold_addr", bus_addr, cap_addr);
            chk("hold_be", 32'(bus_be), 32'(cap_be));
            chk("hold_wdata", bus_wdata, cap_wdata);
          end
          chk("access_stall", 32'(stall), 32'd1);
          if (bus_ack) begin
            in_access    = 1'b0;
            done_pending = 1'b1;
          end
        end
        if (fault) begin
          if (fault_q.size() == 0) fail_now("unexpected_fault");
          else begin
            void'(fault_q.pop_front());
            chk("fault_no_req", 32'(bus_req), 32'd0);
            chk("fault_no_stall", 32'(stall), 32'd0);
          end
        end
      end
    end
  end

  // Driver: one access, with bus_ack raised in the ackc-th ACCESS cycle
  task automatic do_op(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit [31:0] rdw, input int ackc);
    bit       ok;
    int       stall_cnt;
    bus_exp_t e;
    ok = legal_op(we, f3, a);
    if (ok) begin
      e.we = we;
      e.a  = {a[31:2], 2'b00};
      e.be = we ? store_be(f3, a) : 4'hF;
      e.wd = we ? store_wd(f3, wd) : 32'd0;
      bus_q.push_back(e);
      if (!we) model_rd = load_model(f3, a, rdw);
      rd_q.push_back(model_rd);
    end else begin
      fault_q.push_back(1);
    end
    @(posedge clk); #1;
    mem_en = 1'b1; mem_write = we; funct3 = f3; addr = a;
    write_data = wd; bus_rdata = rdw; bus_ack = 1'b0;
    stall_cnt = 0;
    @(negedge clk);
    if (stall) stall_cnt++;
    if (ok) begin
      for (int k = 1; k <= ackc; k++) begin
        @(posedge clk); #1;
        bus_ack = (k == ackc);
        @(negedge clk);
        if (stall) stall_cnt++;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      if (stall) stall_cnt++;
      chk("stall_cycles", 32'(stall_cnt), 32'(ackc + 1));
    end else begin
      chk("illegal_req", 32'(bus_req), 32'd0);
      chk("illegal_read_data", read_data, model_rd);
      chk("illegal_stall_cycles", 32'(stall_cnt), 32'd0);
    end
    @(posedge clk); #1;
    mem_en = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_bus_req", 32'(bus_req), 32'd0);
    chk("reset_bus_we", 32'(bus_we), 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    chk("reset_bus_be", 32'(bus_be), 32'd0);
    chk("reset_bus_wdata", bus_wdata, 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1);
    do_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1);
    do_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h11111111, 1);
    do_op(1'b0, 3'b001, 32'h203, 32'h0, 32'h22222222, 1);
    do_op(1'b0, 3'b001, 32'h402, 32'h0, 32'h9ABC1234, 3);
    do_op(1'b1, 3'b011, 32'h400, 32'h5, 32'h0, 1);

    // bus_ack with no request outstanding must be ignored
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("idle_ack_req", 32'(bus_req), 32'd0);
      chk("idle_ack_read_data", read_data, model_rd);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;

    // Reset in the middle of an ACCESS abandons the transaction
    bus_q.push_back('{1'b0, 32'h300, 4'hF, 32'd0});
    @(posedge clk); #1;
    mem_en = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
    bus_rdata = 32'h55AA55AA; bus_ack = 1'b0;
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(negedge clk);
    chk("pre_reset_req", 32'(bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_req", 32'(bus_req), 32'd0);
    chk("mid_reset_read_data", read_data, 32'd0);
    chk("mid_reset_stall", 32'(stall), 32'd0);
    model_rd = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    do_op(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 2);

    for (int n = 0; n < 80; n++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom & 32'h00000FFF, $urandom, $urandom,
            int'($urandom_range(1, 3)));
    end

    @(posedge clk); @(negedge clk);
    chk("pending_requests", 32'(bus_q.size()), 32'd0);
    chk("pending_results", 32'(rd_q.size()), 32'd0);
    chk("pending_faults", 32'(fault_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
